square_draw_arbiter: RTL and testbench
======================================

Name: square_draw_arbiter

Overview:
Round-robin arbiter that shares one square-drawing engine (raster-scan coordinate generator) among N_REQ independent requesters. It latches the winning request's origin and colour, launches the drawer, and forwards each generated coordinate with the requester's colour as a pixel write to the frame-buffer port. When the square is finished it acknowledges the requester. It sits between game/control logic and the VGA frame-buffer writer.

Parameters:
N_REQ, 4, number of requesters (2..8)
COLOR_W, 1, pixel colour width
SCREEN_W, 640, horizontal pixel limit (clipping only)
SCREEN_H, 480, vertical pixel limit (clipping only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req  in  N_REQ  per-requester draw request; held high with its operands stable until ack
req_x0  in  N_REQ*11  packed origin x per requester
req_y0  in  N_REQ*11  packed origin y per requester
req_color  in  N_REQ*COLOR_W  packed colour per requester
ack  out  N_REQ  one-hot, one-cycle pulse when that requester's square is complete
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(N_REQ)  index of current/last granted requester
drw_start  out  1  drawer start, one-cycle pulse
drw_x0  out  11  drawer origin x, held stable for the whole operation
drw_y0  out  11  drawer origin y, held stable for the whole operation
drw_x  in  11  drawer current x
drw_y  in  11  drawer current y
drw_done  in  1  drawer completion pulse
pix_x  out  11  pixel write x (= drw_x, combinational pass-through)
pix_y  out  11  pixel write y (= drw_y)
pix_color  out  COLOR_W  latched colour of granted requester
pix_we  out  1  pixel write enable

Behaviour:
- Reset values: state IDLE, ack=0, busy=0, grant_id=0, drw_start=0, drw_x0=drw_y0=0, pix_color=0, pix_we=0, rr pointer=N_REQ-1 (requester 0 wins first).
- FSM: IDLE -> LAUNCH -> DRAW -> ACK -> SETTLE -> IDLE.
- IDLE: if any req bit set, pick the first set bit searching upward from (rr_ptr+1) mod N_REQ with wrap-around. Register grant_id, drw_x0/drw_y0, and pix_color from that requester. Set rr_ptr=winner. Go to LAUNCH. No req means stay in IDLE.
- LAUNCH: drw_start=1 for exactly this cycle, then go to DRAW.
- DRAW: pix_we=1 every cycle. On drw_done=1, go to ACK; pix_we is still 1 in that cycle, because the final coordinate is valid with done. Repeat writes to the same pixel are permitted.
- ACK: ack[grant_id]=1 for one cycle. Operand registers are unchanged.
- SETTLE: one idle cycle so the drawer returns to its idle state and the requester can drop req. req is not sampled in this state.
- Latency: req seen in IDLE at cycle t -> drw_start at t+1 -> first pix_we at t+2. ack follows drw_done by exactly 1 cycle. Next grant is possible at ack+2.
- Fairness: a requester that re-asserts immediately loses to any other pending requester.
- Requests that drop before grant are ignored; no latching of pending requests.
- Widths: 11-bit unsigned coordinates, no arithmetic in this block.
- Reset mid-operation: abort immediately and return to reset values. The drawer shares the same reset. No ack is issued for the aborted request.

Optional Feature:
- Macro SQUARE_ARB_CLIP_EN.
- Defined: pix_we is additionally gated to 0 when drw_x >= SCREEN_W or drw_y >= SCREEN_H. FSM timing and ack are unchanged.
- Undefined: no gating; SCREEN_W/SCREEN_H are unused.

Decomposition:
- Package square_arb_pkg: state enum (IDLE, LAUNCH, DRAW, ACK, SETTLE) and the 11-bit coordinate typedef.
- Sub-module rr_pick: combinational round-robin selector with ports req, rr_ptr, valid, winner. It is reused by later arbiters.
- The drawer is instantiated outside this block.

Test Plan:
- Single request: req=4'b0001, x0=20, y0=20, colour 1. With a SIZE=10 drawer this gives 121 distinct (x,y) writes covering 20..30 x 20..30, then ack=4'b0001 one cycle after drw_done, and busy low 2 cycles later.
- Contention: all four requesters high from reset. Grants go in order 0,1,2,3; each ack arrives before the next drw_start; pix_color switches per grant.
- Fairness: requesters 0 and 2 hold req continuously. Grants alternate 0,2,0,2; requester 0 never wins twice in a row.
- Reset mid-draw: assert reset for 1 cycle during DRAW with about 50 pixels written. Next cycle pix_we=0, busy=0, no ack; a fresh request restarts from its origin with requester 0 priority.
- Stability: while busy, change req_x0 of the granted requester. drw_x0/drw_y0/pix_color must not change until the next grant.
- Clipping: with SQUARE_ARB_CLIP_EN, draw x0=635, y0=475. Only 5x5=25 writes occur, with no pix_we for x>=640 or y>=480. Without the macro, 121 writes occur.

Source files
------------

// File: rtl/square_arb_pkg.sv
// Shared types for the square-draw arbiter.
//   arb_state_t : arbiter FSM states
//   coord_t     : 11-bit unsigned screen coordinate
package square_arb_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    DRAW   = 3'd2,
    ACK    = 3'd3,
    SETTLE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/square_draw_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Searches upward from (rr_ptr + 1) mod N_REQ, wrapping, and returns the
// first set request bit.
//   req    : request vector
//   rr_ptr : index of the previous winner
//   valid  : at least one request is set
//   winner : index of the selected request (0 when valid is low)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             valid,
  output logic [ID_W-1:0]  winner
);

  always_comb begin
    int          idx;
    logic [ID_W-1:0] idx_v;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_v  = '0;
    // Offset 1..N_REQ so the previous winner is considered last.
    for (int i = 1; i <= N_REQ; i++) begin
      idx   = (int'(rr_ptr) + i) % N_REQ;
      idx_v = ID_W'(idx);
      if (!valid && req[idx_v]) begin
        valid  = 1'b1;
        winner = idx_v;
      end
    end
  end

endmodule

// File: rtl/square_draw_arbiter.sv
// square_draw_arbiter: shares one raster-scan square drawer among N_REQ
// requesters. Latches the winner's origin and colour, pulses the drawer
// start, forwards drawer coordinates as pixel writes, then acks.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req                   : per-requester draw request (held until ack)
//   req_x0/req_y0         : packed 11-bit origins, requester i at [i*11 +: 11]
//   req_color             : packed colours, requester i at [i*COLOR_W +: COLOR_W]
//   ack                   : one-hot, one-cycle completion pulse
//   busy                  : high in every state except IDLE
//   grant_id              : current/last granted requester
//   drw_start             : one-cycle drawer start pulse
//   drw_x0/drw_y0         : latched origin, stable for the whole operation
//   drw_x/drw_y/drw_done  : drawer coordinate stream and completion pulse
//   pix_x/pix_y           : pixel write coordinate (pass-through of drawer)
//   pix_color             : latched colour of granted requester
//   pix_we                : pixel write enable
//
// Build option: define SQUARE_ARB_CLIP_EN to suppress pixel writes outside
// SCREEN_W x SCREEN_H. Without it no clipping is done.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for any request; grant and latch operands on exit
// LAUNCH | drw_start pulse
// DRAW   | pixel write every cycle until drw_done (inclusive)
// ACK    | ack pulse to the granted requester
// SETTLE | dead cycle: drawer returns idle, requester drops req
module square_draw_arbiter
  import square_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int COLOR_W  = 1,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*COORD_W-1:0]   req_x0,
  input  logic [N_REQ*COORD_W-1:0]   req_y0,
  input  logic [N_REQ*COLOR_W-1:0]   req_color,
  output logic [N_REQ-1:0]           ack,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       drw_start,
  output logic [COORD_W-1:0]         drw_x0,
  output logic [COORD_W-1:0]         drw_y0,
  input  logic [COORD_W-1:0]         drw_x,
  input  logic [COORD_W-1:0]         drw_y,
  input  logic                       drw_done,
  output logic [COORD_W-1:0]         pix_x,
  output logic [COORD_W-1:0]         pix_y,
  output logic [COLOR_W-1:0]         pix_color,
  output logic                       pix_we
);

  localparam int ID_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("square_draw_arbiter: N_REQ must be 2..8");
  end
  if (SCREEN_W < 1 || SCREEN_W > 2048 || SCREEN_H < 1 || SCREEN_H > 2048) begin : g_bad_screen
    $error("square_draw_arbiter: SCREEN_W/SCREEN_H must fit the 11-bit coordinate space");
  end

  arb_state_t          state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant_r;
  coord_t              x0_r, y0_r;
  logic [COLOR_W-1:0]  color_r;

  logic                pick_valid;
  logic [ID_W-1:0]     pick_winner;
  logic                clip_ok;
  logic                draw_we;

  coord_t              lane_x0    [N_REQ];
  coord_t              lane_y0    [N_REQ];
  logic [COLOR_W-1:0]  lane_color [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane_x0[g]    = req_x0[g*COORD_W +: COORD_W];
    assign lane_y0[g]    = req_y0[g*COORD_W +: COORD_W];
    assign lane_color[g] = req_color[g*COLOR_W +: COLOR_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    drw_start = 1'b0;
    draw_we   = 1'b0;
    ack       = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pick_valid) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        drw_start = 1'b1;
        state_nxt = DRAW;
      end
      DRAW: begin
        // The last coordinate arrives together with drw_done, so it is
        // still written in this cycle.
        draw_we = 1'b1;
        if (drw_done) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        ack[grant_r] = 1'b1;
        state_nxt    = SETTLE;
      end
      SETTLE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operands are captured once at grant and held until the next grant, so
  // requesters may change their inputs after being granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= ID_W'(N_REQ - 1);
      grant_r <= '0;
      x0_r    <= '0;
      y0_r    <= '0;
      color_r <= '0;
    end else if (state == IDLE && pick_valid) begin
      rr_ptr  <= pick_winner;
      grant_r <= pick_winner;
      x0_r    <= lane_x0[pick_winner];
      y0_r    <= lane_y0[pick_winner];
      color_r <= lane_color[pick_winner];
    end
  end

`ifdef SQUARE_ARB_CLIP_EN
  // 12-bit compare so a limit of 2048 is representable.
  assign clip_ok = ({1'b0, drw_x} < 12'(SCREEN_W)) &&
                   ({1'b0, drw_y} < 12'(SCREEN_H));
`else
  assign clip_ok = 1'b1;
`endif

  assign pix_we    = draw_we & clip_ok;
  assign pix_x     = drw_x;
  assign pix_y     = drw_y;
  assign pix_color = color_r;
  assign grant_id  = grant_r;
  assign drw_x0    = x0_r;
  assign drw_y0    = y0_r;

endmodule

// File: tb/tb_square_draw_arbiter.sv
// Bench for square_draw_arbiter with a behavioural SIZE=10 raster drawer.
module tb_square_draw_arbiter;
  import square_arb_pkg::*;

  localparam int N    = 4;
  localparam int CW   = 1;
  localparam int SIZE = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*11-1:0]   req_x0, req_y0;
  logic [N*CW-1:0]   req_color;
  logic [N-1:0]      ack;
  logic              busy;
  logic [1:0]        grant_id;
  logic              drw_start;
  logic [10:0]       drw_x0, drw_y0, drw_x, drw_y;
  logic              drw_done;
  logic [10:0]       pix_x, pix_y;
  logic [CW-1:0]     pix_color;
  logic              pix_we;

  logic [10:0]       lx [N];
  logic [10:0]       ly [N];
  logic [CW-1:0]     lc [N];

  always #5 clk = ~clk;

  always_comb begin
    req_x0    = '0;
    req_y0    = '0;
    req_color = '0;
    for (int i = 0; i < N; i++) begin
      req_x0[i*11 +: 11]   = lx[i];
      req_y0[i*11 +: 11]   = ly[i];
      req_color[i*CW +: CW] = lc[i];
    end
  end

  square_draw_arbiter #(.N_REQ(N), .COLOR_W(CW), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk(clk), .reset(reset), .req(req), .req_x0(req_x0), .req_y0(req_y0),
    .req_color(req_color), .ack(ack), .busy(busy), .grant_id(grant_id),
    .drw_start(drw_start), .drw_x0(drw_x0), .drw_y0(drw_y0), .drw_x(drw_x),
    .drw_y(drw_y), .drw_done(drw_done), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .pix_we(pix_we)
  );

  // Behavioural drawer: raster x0..x0+SIZE by y0..y0+SIZE, done with last point.
  logic        d_active;
  logic [10:0] d_sx, d_sy;
  assign drw_done = d_active && (drw_x == d_sx + 11'(SIZE)) && (drw_y == d_sy + 11'(SIZE));

  always @(posedge clk) begin
    if (reset) begin
      d_active <= 1'b0;
      drw_x    <= '0;
      drw_y    <= '0;
      d_sx     <= '0;
      d_sy     <= '0;
    end else if (drw_start) begin
      d_active <= 1'b1;
      d_sx     <= drw_x0;
      d_sy     <= drw_y0;
      drw_x    <= drw_x0;
      drw_y    <= drw_y0;
    end else if (d_active) begin
      if (drw_done) begin
        d_active <= 1'b0;
      end else if (drw_x == d_sx + 11'(SIZE)) begin
        drw_x <= d_sx;
        drw_y <= drw_y + 11'd1;
      end else begin
        drw_x <= drw_x + 11'd1;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int span(input int o, input int lim);
    int n = 0;
    for (int v = o; v <= o + SIZE; v++) begin
`ifdef SQUARE_ARB_CLIP_EN
      if (v < lim) n++;
`else
      if (lim > 0) n++;
`endif
    end
    return n;
  endfunction

  typedef struct {
    int id;
    int x0;
    int y0;
    int color;
    int writes;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   writes   = 0;
  bit   done_prev = 1'b0;

  task automatic push_exp(input int id, input int x0, input int y0, input int c);
    exp_t e;
    e.id = id; e.x0 = x0; e.y0 = y0; e.color = c;
    e.writes = span(x0, 640) * span(y0, 480);
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        have_cur  = 1'b0;
        writes    = 0;
        done_prev = 1'b0;
      end else begin
        if (drw_start) begin
          chk("start_after_prev_ack", 64'(have_cur), 64'(0));
          if (exp_q.size() == 0) begin
            chk("start_expected", 64'(0), 64'(1));
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            writes   = 0;
            chk("grant_id", 64'(grant_id), 64'(cur.id));
            chk("drw_x0", 64'(drw_x0), 64'(cur.x0));
            chk("drw_y0", 64'(drw_y0), 64'(cur.y0));
            chk("pix_color", 64'(pix_color), 64'(cur.color));
          end
        end
        if (pix_we) begin
          writes++;
          if (have_cur) begin
            chk("pix_in_square", 64'((int'(pix_x) >= cur.x0) && (int'(pix_x) <= cur.x0 + SIZE) &&
                                     (int'(pix_y) >= cur.y0) && (int'(pix_y) <= cur.y0 + SIZE)), 64'(1));
`ifdef SQUARE_ARB_CLIP_EN
            chk("pix_clipped", 64'((pix_x < 11'd640) && (pix_y < 11'd480)), 64'(1));
`endif
            chk("x0_stable", 64'(drw_x0), 64'(cur.x0));
            chk("y0_stable", 64'(drw_y0), 64'(cur.y0));
            chk("color_stable", 64'(pix_color), 64'(cur.color));
          end else begin
            chk("pix_we_without_grant", 64'(0), 64'(1));
          end
        end
        if (ack != '0) begin
          if (have_cur) begin
            chk("ack_onehot", 64'(ack), 64'(1) << cur.id);
            chk("write_count", 64'(writes), 64'(cur.writes));
            chk("ack_after_done", 64'(done_prev), 64'(1));
            have_cur = 1'b0;
          end else begin
            chk("ack_unexpected", 64'(ack), 64'(0));
          end
        end
        done_prev = drw_done;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack;
    bit seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      step();
      if (ack != '0) seen = 1'b1;
    end
    if (!seen) chk("ack_timeout", 64'(0), 64'(1));
  endtask

  task automatic set_lane(input int i, input int x, input int y, input int c);
    lx[i] = 11'(x);
    ly[i] = 11'(y);
    lc[i] = CW'(c);
  endtask

  typedef struct {
    logic [N-1:0] req;
    int x0;
    int y0;
    int color;
    int exp_id;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'b1010,  40,  50, 1, 3};
    vecs[1] = '{4'b0110,  60,  70, 0, 1};
    vecs[2] = '{4'b1001,  80,  90, 1, 3};
    vecs[3] = '{4'b1000,  81,  91, 0, 3};
    vecs[4] = '{4'b1111, 120, 130, 1, 0};
    vecs[5] = '{4'b0101, 150, 160, 0, 2};
    vecs[6] = '{4'b0001, 635, 475, 1, 0};
    vecs[7] = '{4'b0100, 2000, 1000, 1, 2};
    vecs[8] = '{4'b0010,   0,   0, 1, 1};

    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < N; i++) set_lane(i, 0, 0, 0);
    repeat (3) step();
    reset = 1'b0;
    step();

    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_drw_start", 64'(drw_start), 64'(0));
    chk("rst_drw_x0", 64'(drw_x0), 64'(0));
    chk("rst_drw_y0", 64'(drw_y0), 64'(0));
    chk("rst_pix_color", 64'(pix_color), 64'(0));
    chk("rst_pix_we", 64'(pix_we), 64'(0));

    // Single request: latency and post-ack busy timing.
    set_lane(0, 20, 20, 1);
    push_exp(0, 20, 20, 1);
    req = 4'b0001;
    step();
    chk("latency_start", 64'(drw_start), 64'(1));
    step();
    chk("latency_first_we", 64'(pix_we), 64'(1));
    wait_ack();
    req = '0;
    step();
    chk("busy_settle", 64'(busy), 64'(1));
    step();
    chk("busy_idle", 64'(busy), 64'(0));

    // Contention from reset: 0,1,2,3.
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    for (int i = 0; i < N; i++) begin
      set_lane(i, 100 + 30 * i, 200 + 20 * i, (i + 1) % 2);
      push_exp(i, 100 + 30 * i, 200 + 20 * i, (i + 1) % 2);
    end
    req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      wait_ack();
      req = req & ~ack;
    end
    step(); step();

    // Fairness: 0 and 2 held continuously.
    set_lane(0, 300, 310, 1);
    set_lane(2, 320, 330, 0);
    push_exp(0, 300, 310, 1);
    push_exp(2, 320, 330, 0);
    push_exp(0, 300, 310, 1);
    push_exp(2, 320, 330, 0);
    req = 4'b0101;
    for (int k = 0; k < 4; k++) wait_ack();
    req = '0;
    step(); step();

    // Table-driven vectors; round-robin history carries across entries.
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < N; i++) set_lane(i, 500 + i, 400 + i, i % 2);
      set_lane(vecs[v].exp_id, vecs[v].x0, vecs[v].y0, vecs[v].color);
      push_exp(vecs[v].exp_id, vecs[v].x0, vecs[v].y0, vecs[v].color);
      req = vecs[v].req;
      wait_ack();
      chk("vec_grant", 64'(grant_id), 64'(vecs[v].exp_id));
      req = '0;
      step(); step();
    end

    // Stability: change granted requester's operands mid-draw.
    set_lane(0, 50, 60, 1);
    push_exp(0, 50, 60, 1);
    req = 4'b0001;
    for (int c = 0; c < 20 && !drw_start; c++) step();
    repeat (5) step();
    set_lane(0, 400, 401, 0);
    wait_ack();
    chk("x0_hold_ack", 64'(drw_x0), 64'(50));
    chk("color_hold_ack", 64'(pix_color), 64'(1));
    req = '0;
    step(); step();

    // Reset mid-draw, then a fresh request from requester-0 priority.
    set_lane(1, 100, 100, 1);
    push_exp(1, 100, 100, 1);
    req = 4'b0010;
    for (int c = 0; c < 300 && !(have_cur && writes >= 50); c++) step();
    chk("mid_draw_reached", 64'(have_cur && writes >= 50), 64'(1));
    reset = 1'b1;
    req   = '0;
    step();
    reset = 1'b0;
    chk("abort_pix_we", 64'(pix_we), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_ack", 64'(ack), 64'(0));
    chk("abort_drw_x0", 64'(drw_x0), 64'(0));
    repeat (3) begin
      step();
      chk("no_ack_after_abort", 64'(ack), 64'(0));
    end
    set_lane(0, 10, 12, 0);
    set_lane(1, 700, 700, 1);
    push_exp(0, 10, 12, 0);
    req = 4'b0011;
    wait_ack();
    req = '0;
    step(); step();

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
